// File: rtl/osc_pkg.sv
// Shared oscilloscope types: acquisition state encoding and the sample type
// used by both the capture buffer and the waveform renderer.
package osc_pkg;

    localparam int SAMPLE_W = 12;
    localparam int DEPTH    = 256;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        ARMED,
        CAPTURE,
        READY
    } capture_state_t;

endpackage

// File: rtl/trigger_detect.sv
// Level-crossing trigger and auto-trigger timeout for the capture buffer.
// Both outputs are single-cycle pulses, only active while arm is high.
module trigger_detect
    import osc_pkg::*;
#(
    parameter int WIDTH        = SAMPLE_W,
    parameter int AUTO_TIMEOUT = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             accept,
    input  logic             arm,
    input  logic [WIDTH-1:0] trig_level,
    input  logic             trig_slope,
    output logic             trig,
    output logic             timeout
);

    localparam int               TO_W    = $clog2(AUTO_TIMEOUT);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(AUTO_TIMEOUT - 1);

    logic [WIDTH-1:0] prev_q, prev_d;
    logic             prev_ok_q, prev_ok_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             crossing;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        prev_d    = prev_q;
        prev_ok_d = prev_ok_q;
        to_cnt_d  = to_cnt_q;

        crossing = trig_slope ? ((prev_q > trig_level) && (sample_in <= trig_level))
                              : ((prev_q < trig_level) && (sample_in >= trig_level));
        trig     = arm && accept && prev_ok_q && crossing;
        timeout  = arm && (to_cnt_q == TO_LAST);

        // Leaving ARMED clears the history so the next arming starts fresh.
        if (!arm) begin
            prev_ok_d = 1'b0;
            to_cnt_d  = '0;
        end else begin
            if (!timeout) begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
            if (accept) begin
                prev_d    = sample_in;
                prev_ok_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            prev_q    <= '0;
            prev_ok_q <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            prev_q    <= prev_d;
            prev_ok_q <= prev_ok_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

endmodule

// File: rtl/capture_buffer.sv
// Acquisition stage: decimate, trigger, record DEPTH samples, then publish the
// finished record to the renderer only on frame_start so a trace never tears.
module capture_buffer #(
    parameter int DEPTH        = osc_pkg::DEPTH,
    parameter int SAMPLE_W     = osc_pkg::SAMPLE_W,
    parameter int AUTO_TIMEOUT = 1_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic                trig_slope,
    input  logic [3:0]          decim,
    input  logic                frame_start,
    output logic [SAMPLE_W-1:0] data_display [0:DEPTH-1],
    output logic                capture_busy,
    output logic                trig_seen
);

    localparam int AW    = $clog2(DEPTH);
    localparam int IDX_W = AW + 1;

    osc_pkg::capture_state_t state_q, state_d;

    logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
    logic [3:0]          dec_cnt_q, dec_cnt_d;
    logic [3:0]          decim_q, decim_d;
    logic                fresh_q, fresh_d;
    logic                trig_flag_q, trig_flag_d;
    logic                trig_seen_q, trig_seen_d;
    logic                busy_q, busy_d;

    logic [SAMPLE_W-1:0] rec_buf   [0:DEPTH-1];
    logic [SAMPLE_W-1:0] display_q [0:DEPTH-1];

    logic                accept;
    logic                arm;
    logic                trig;
    logic                timeout;
    logic                buf_we;
    logic [AW-1:0]       buf_addr;
    logic                publish;

    assign accept = sample_valid && (dec_cnt_q == 4'd0);
    assign arm    = (state_q == osc_pkg::ARMED);

    trigger_detect #(
        .WIDTH        (SAMPLE_W),
        .AUTO_TIMEOUT (AUTO_TIMEOUT)
    ) u_trigger_detect (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_in  (sample_in),
        .accept     (accept),
        .arm        (arm),
        .trig_level (trig_level),
        .trig_slope (trig_slope),
        .trig       (trig),
        .timeout    (timeout)
    );

    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        trig_flag_d = trig_flag_q;
        trig_seen_d = trig_seen_q;
        fresh_d     = 1'b0;
        buf_we      = 1'b0;
        buf_addr    = wr_idx_q[AW-1:0];
        publish     = 1'b0;

        // decim is captured in the first ARMED cycle and held for the record.
        decim_d   = fresh_q ? decim : decim_q;
        dec_cnt_d = dec_cnt_q;
        if (sample_valid) begin
            dec_cnt_d = (dec_cnt_q == decim_d) ? 4'd0 : dec_cnt_q + 4'd1;
        end

        case (state_q)
            osc_pkg::ARMED: begin
                // A real crossing takes priority over a coincident timeout.
                if (trig) begin
                    buf_we      = 1'b1;
                    buf_addr    = '0;
                    wr_idx_d    = IDX_W'(1);
                    trig_flag_d = 1'b1;
                    state_d     = osc_pkg::CAPTURE;
                end else if (timeout) begin
                    wr_idx_d    = '0;
                    trig_flag_d = 1'b0;
                    state_d     = osc_pkg::CAPTURE;
                end
            end
            osc_pkg::CAPTURE: begin
                if (accept) begin
                    buf_we   = 1'b1;
                    wr_idx_d = wr_idx_q + IDX_W'(1);
                    if (wr_idx_q == IDX_W'(DEPTH - 1)) begin
                        state_d = osc_pkg::READY;
                    end
                end
            end
            osc_pkg::READY: begin
                if (frame_start) begin
                    publish     = 1'b1;
                    trig_seen_d = trig_flag_q;
                    dec_cnt_d   = 4'd0;
                    fresh_d     = 1'b1;
                    state_d     = osc_pkg::ARMED;
                end
            end
            default: begin
                state_d = osc_pkg::ARMED;
            end
        endcase

        busy_d = (state_d != osc_pkg::READY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= osc_pkg::ARMED;
            wr_idx_q    <= '0;
            dec_cnt_q   <= 4'd0;
            decim_q     <= 4'd0;
            fresh_q     <= 1'b1;
            trig_flag_q <= 1'b0;
            trig_seen_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            dec_cnt_q   <= dec_cnt_d;
            decim_q     <= decim_d;
            fresh_q     <= fresh_d;
            trig_flag_q <= trig_flag_d;
            trig_seen_q <= trig_seen_d;
            busy_q      <= busy_d;
        end
    end

    // NOTE: the record memory has no reset; its contents are never visible until fully rewritten.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            rec_buf[buf_addr] <= sample_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                display_q[i] <= '0;
            end
        end else if (publish) begin
            display_q <= rec_buf;
        end
    end

    assign data_display = display_q;
    assign capture_busy = busy_q;
    assign trig_seen    = trig_seen_q;

endmodule

// File: tb/tb_capture_buffer.sv
// Scoreboard bench for capture_buffer: expected records are queued as stimulus
// is issued; a monitor compares each record when the DUT publishes it.
module tb_capture_buffer;

    localparam int DEPTH = 256;
    localparam int W     = 12;
    localparam int TO    = 50;

    typedef struct packed {
        logic                    seen;
        logic [DEPTH-1:0][W-1:0] d;
    } rec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sample_in;
    logic         sample_valid;
    logic [W-1:0] trig_level;
    logic         trig_slope;
    logic [3:0]   decim;
    logic         frame_start;
    logic [W-1:0] data_display [0:DEPTH-1];
    logic         capture_busy;
    logic         trig_seen;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_pub = 0;
    rec_t exp_q[$];
    rec_t last_pub = '0;

    capture_buffer #(
        .DEPTH        (DEPTH),
        .SAMPLE_W     (W),
        .AUTO_TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .trig_level   (trig_level),
        .trig_slope   (trig_slope),
        .decim        (decim),
        .frame_start  (frame_start),
        .data_display (data_display),
        .capture_busy (capture_busy),
        .trig_seen    (trig_seen)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic rec_t grab();
        rec_t r;
        for (int i = 0; i < DEPTH; i++) r.d[i] = data_display[i];
        r.seen = trig_seen;
        return r;
    endfunction

    // Record whose entry i is (start + step*i) mod 4096.
    function automatic rec_t ramp_rec(input int start, input int step, input logic seen);
        rec_t r;
        for (int i = 0; i < DEPTH; i++) r.d[i] = W'((start + step * i) & 4095);
        r.seen = seen;
        return r;
    endfunction

    task automatic compare_rec(input string name, input rec_t got, input rec_t exp);
        int   idx = 0;
        logic found = 1'b0;
        check($sformatf("%s trig_seen", name), int'(got.seen), int'(exp.seen));
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && got.d[i] !== exp.d[i]) begin
                idx   = i;
                found = 1'b1;
            end
        end
        check($sformatf("%s data_display[%0d]", name, idx), int'(got.d[idx]), int'(exp.d[idx]));
    endtask

    // Monitor: capture_busy rising marks a publish (or reset release, whose record is all zeros).
    initial begin : monitor
        logic busy_prev;
        rec_t e;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (capture_busy === 1'b1 && busy_prev === 1'b0) begin
                check("expected record pending at publish", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    compare_rec($sformatf("record %0d", n_pub), grab(), e);
                    last_pub = e;
                    n_pub++;
                end
            end
            busy_prev = capture_busy;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d records still expected", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] v, input logic fs);
        sample_in    = v;
        sample_valid = 1'b1;
        frame_start  = fs;
        tick();
        sample_valid = 1'b0;
        frame_start  = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // One valid sample per cycle; frame_start rides along at sample indices fa/fb/fc.
    task automatic stream_ramp(input int start, input int step, input int n,
                               input int fa, input int fb, input int fc);
        for (int k = 0; k < n; k++) begin
            drive(W'((start + step * k) & 4095), (k == fa) || (k == fb) || (k == fc));
        end
    endtask

    initial begin : stimulus
        sample_in    = '0;
        sample_valid = 1'b0;
        trig_level   = 12'd2048;
        trig_slope   = 1'b0;
        decim        = 4'd0;
        frame_start  = 1'b0;

        // Reset state; the record seen at reset release must be all zeros.
        exp_q.push_back('0);
        repeat (3) tick();
        check("busy during reset", int'(capture_busy), 0);
        check("trig_seen during reset", int'(trig_seen), 0);
        rst_n = 1'b1;

        // Rising trigger at 2048, ramp step 16 starting 10 samples below the level.
        exp_q.push_back(ramp_rec(2048, 16, 1'b1));
        stream_ramp(1888, 16, 266, -1, -1, -1);
        check("busy low once record full (rising)", int'(capture_busy), 0);
        repeat (5) tick();

        // Falling trigger at 1000: first sample <= 1000 is 991.
        trig_level = 12'd1000;
        trig_slope = 1'b1;
        pulse_frame();
        exp_q.push_back(ramp_rec(991, -16, 1'b1));
        stream_ramp(4095 - 16 * 184, -16, 266, -1, -1, -1);
        check("busy low once record full (falling)", int'(capture_busy), 0);

        // Decimation by 4: accepted samples 64 apart, trigger on accepted 2048.
        trig_level = 12'd2048;
        trig_slope = 1'b0;
        decim      = 4'd3;
        pulse_frame();
        exp_q.push_back(ramp_rec(2048, 64, 1'b1));
        stream_ramp(1728, 16, 1040, -1, -1, -1);
        check("busy before last decimated sample", int'(capture_busy), 1);
        drive(W'((1728 + 16 * 1040) & 4095), 1'b0);
        check("busy after last decimated sample", int'(capture_busy), 0);

        // Auto-trigger: below-level ramp 100,101,... so buf[0] pins the timeout cycle.
        // Timeout fires at the end of ARMED cycle 49; the cycle-50 sample (150) is buf[0].
        decim = 4'd0;
        pulse_frame();
        exp_q.push_back(ramp_rec(150, 1, 1'b0));
        stream_ramp(100, 1, 306, -1, -1, -1);
        check("busy low once record full (auto)", int'(capture_busy), 0);

        // Publish gating: frame_start in ARMED, in CAPTURE and with the final write.
        pulse_frame();
        exp_q.push_back(ramp_rec(2048, 16, 1'b1));
        stream_ramp(1888, 16, 266, 5, 100, 265);
        check("busy low once record full (gating)", int'(capture_busy), 0);
        compare_rec("display held through early frame_start", grab(), last_pub);
        pulse_frame();

        // Reset mid-capture after buf[0..99] written (wr_idx = 100).
        stream_ramp(1888, 16, 110, -1, -1, -1);
        rst_n = 1'b0;
        exp_q.push_back('0);
        tick();
        check("busy during mid-capture reset", int'(capture_busy), 0);
        compare_rec("display cleared by reset", grab(), '0);
        trig_level = 12'd3000;
        rst_n = 1'b1;
        exp_q.push_back(ramp_rec(3000, 16, 1'b1));
        stream_ramp(2840, 16, 266, -1, -1, -1);
        compare_rec("display zero before new publish", grab(), '0);
        pulse_frame();

        repeat (3) tick();
        check("expected records left unpublished", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/capture_buffer.md
# capture_buffer

Acquisition stage directly upstream of the waveform renderer. It decimates the 12-bit ADC sample stream, waits for a level-crossing trigger (or an auto-trigger timeout), and records 256 consecutive samples. It publishes the completed record to the renderer's `data_display[0:255]` array only at frame start, so a trace never tears mid-frame.

## Interface
- `DEPTH`, 256, samples per record; must be a power of two.
- `SAMPLE_W`, 12, sample width in bits.
- `AUTO_TIMEOUT`, 1_000_000, cycles spent in ARMED before a forced trigger.
- `clk` in 1: single system clock.
- `rst_n` in 1: reset; **asynchronous, active-low**.
- `sample_in` in 12: ADC sample.
- `sample_valid` in 1: `sample_in` is valid this cycle.
- `trig_level` in 12: trigger threshold, unsigned.
- `trig_slope` in 1: 0 = rising edge, 1 = falling edge.
- `decim` in 4: keep 1 of every `decim`+1 valid samples.
- `frame_start` in 1: one-cycle pulse at the start of vertical blank.
- `data_display` out 12 x [0:255]: published record, consumed by the renderer.
- `capture_busy` out 1: high while the state is ARMED or CAPTURE.
- `trig_seen` out 1: the published record came from a real crossing (0 = auto-trigger).

## Operation
**Accepted sample**
- A sample is accepted when `sample_valid` is high and `dec_cnt` == 0.
- `dec_cnt` advances on every valid sample and wraps after reaching `decim`.
- `dec_cnt` resets to 0 whenever ARMED is entered.
- `decim` is sampled on entry to ARMED and held constant for the whole record.

**States**
- **ARMED**
  - The first accepted sample only loads `prev` and sets `prev_ok`.
  - Once `prev_ok` is set, a rising trigger is `prev` < `trig_level` and `cur` >= `trig_level`. A falling trigger is `prev` > `trig_level` and `cur` <= `trig_level`.
  - Comparisons are unsigned, 12-bit.
  - On a trigger: `cur` is written to `buf[0]`, `wr_idx` is set to 1, the internal `trig_flag` is set to 1, and the state goes to CAPTURE.
  - `to_cnt` counts every cycle spent in ARMED. When `to_cnt` == `AUTO_TIMEOUT`-1, the state goes to CAPTURE with `wr_idx` = 0 and `trig_flag` = 0. The next accepted sample then becomes `buf[0]`.
- **CAPTURE**
  - Each accepted sample is written to `buf[wr_idx]` and `wr_idx` increments.
  - The write to `buf[DEPTH-1]` moves the state to READY.
- **READY**
  - Incoming samples are ignored.
  - On `frame_start`: all of `buf` is copied to `data_display` in one cycle, `trig_flag` is copied to `trig_seen`, and the state goes to ARMED with `prev_ok` = 0 and `to_cnt` = 0.

**Reset**
- Asynchronous assertion at any point, including mid-capture, forces the state to ARMED.
- It clears `wr_idx`, `dec_cnt`, `to_cnt`, `prev`, `prev_ok` and `trig_flag`.
- It clears `data_display` to all zeros, `trig_seen` to 0 and `capture_busy` to 0.
- `buf` contents are not reset.

**Boundary conditions**
- `frame_start` in the same cycle as the final CAPTURE write: not published. Publication happens on the next `frame_start`.
- `frame_start` while in ARMED or CAPTURE: no effect. `data_display` keeps the previous record.
- A trigger condition and the timeout in the same cycle: the trigger wins, so `trig_flag` = 1.
- `wr_idx` is `$clog2(DEPTH)`+1 bits wide and never wraps within a record.
- `decim` = 0 means every valid sample is accepted.

## Timing
- All outputs are registered.
- `capture_busy` goes high 1 cycle after reset deassertion. It drops on the edge that enters READY and rises on the edge that leaves READY.
- Trigger sample to `buf[0]`: written on the same edge that detects the crossing.
- Publish latency: `data_display` and `trig_seen` change on the first rising edge at which `frame_start` = 1 and the state is READY. They are stable for at least one full frame afterwards.
- Record duration: `DEPTH` x (`decim`+1) valid samples after the trigger.
- `to_cnt` counts clock cycles, not samples.

## Structure
- A shared `osc_pkg` holds:
  - `capture_state_t` enum {ARMED, CAPTURE, READY};
  - `SAMPLE_W` and `DEPTH` constants;
  - the `sample_t` typedef, shared with the renderer's `data_display` port type.
- Sub-module `trigger_detect` holds `prev`/`prev_ok`, the slope compare and `to_cnt`.
  - Inputs: `sample_in`, `accept`, `arm`, `trig_level`, `trig_slope`.
  - Outputs: `trig` and `timeout`, both single-cycle pulses.
- Top level holds the FSM, the decimator, `buf` and the publish register array.

## Test plan
- Rising trigger: ramp 0..4095 step 16, `trig_level`=2048, `trig_slope`=0, `decim`=0 -> after `frame_start`, `data_display[0]`=2048, `[1]`=2064, `[255]`=6128 mod 4096 = 2032, `trig_seen`=1.
- Falling trigger: ramp 4095 down step 16, `trig_level`=1000, `trig_slope`=1 -> `data_display[0]` is the first sample <= 1000 (991), and each following entry is 16 lower.
- Decimation: same ramp with `decim`=3 -> `data_display[1]`-`data_display[0]` = 64, and the record spans 1024 valid samples.
- Auto-trigger: constant 100, `trig_level`=2048, `AUTO_TIMEOUT`=50 -> CAPTURE is entered after 50 cycles in ARMED, and the published record is all 100 with `trig_seen`=0.
- Publish gating: `frame_start` pulsed during CAPTURE, then in the same cycle as the write to `buf[255]` -> `data_display` is unchanged after both; it updates only on the third pulse.
- Reset mid-capture: assert `rst_n`=0 at `wr_idx`=100, release, then trigger anew -> `data_display` is 0 until the new record is published, and the new record starts at the new trigger sample.
